// File: rtl/bank_ticket_machine_fsm_pkg.sv
// Shared types and constants for the bank ticket dispenser/caller.
// Provides the FSM state enum, service indices, queue sizing and the desk-to-service map.
package bank_ticket_machine_fsm_pkg;

   localparam int unsigned QDEPTH_DEF = 4;
   localparam int unsigned TICKET_W   = 7;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned NUM_SVC    = 3;
   localparam int unsigned NUM_DESK   = 4;

   localparam logic [1:0] SVC_GEN  = 2'd0;
   localparam logic [1:0] SVC_LOAN = 2'd1;
   localparam logic [1:0] SVC_CUST = 2'd2;

   // Desks 0..2 serve a fixed queue; desk 3 serves whichever queue is non-empty first
   localparam logic [1:0] DESK0_SVC = SVC_GEN;
   localparam logic [1:0] DESK1_SVC = SVC_LOAN;
   localparam logic [1:0] DESK2_SVC = SVC_CUST;
   localparam logic [1:0] DESK_ANY  = 2'd3;

   localparam logic [TICKET_W-1:0] TICKET_FIRST = 7'd1;
   localparam logic [TICKET_W-1:0] TICKET_LAST  = 7'd127;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CALL  = 2'd2
   } state_e;

   // Lowest set bit index of a request vector (3 when none set)
   function automatic logic [1:0] lowest_set(input logic [3:0] req);
      lowest_set = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) lowest_set = 2'(i);
      end
   endfunction

   // Queue served by a desk; the roaming desk takes general > loan > customer
   function automatic logic [1:0] desk_service(input logic [1:0] desk, input logic [2:0] empty);
      case (desk)
         2'd0:    desk_service = DESK0_SVC;
         2'd1:    desk_service = DESK1_SVC;
         2'd2:    desk_service = DESK2_SVC;
         default: begin
            if (!empty[SVC_GEN])       desk_service = SVC_GEN;
            else if (!empty[SVC_LOAN]) desk_service = SVC_LOAN;
            else                       desk_service = SVC_CUST;
         end
      endcase
   endfunction

endpackage

// File: rtl/bank_ticket_machine_fsm_ticket_fifo.sv
// Per-service ticket FIFO.
// Ports: clk, rst (async active-high), push_i/data_i write, pop_i read,
//        data_o head entry, count_o occupancy, full_o/empty_o status (derived from count).
module ticket_fifo
   import bank_ticket_machine_fsm_pkg::*;
#(
   parameter int unsigned QDEPTH = QDEPTH_DEF,
   parameter int unsigned W      = TICKET_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [W-1:0]     mem_q [QDEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
      bump = (ptr == AW'(QDEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(QDEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= bump(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= bump(rd_ptr_q);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Storage needs no reset: only entries below count are ever read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/bank_ticket_machine_fsm.sv
// Bank ticket dispenser and caller.
// Ports: clk; rst_n (async reset, active-HIGH despite the name);
//        service_ButtonPress[2:0] gen/loan/cust, officer_ButtonPress[3:0] desk calls;
//        Tickernum last issued/called ticket, Desknum last calling desk,
//        ticket_WaitingCustomers {total, cust, loan, gen} counts, ticket_ServiceType one-hot.
module bank_ticket_machine_fsm
   import bank_ticket_machine_fsm_pkg::*;
#(
   parameter int unsigned QDEPTH = QDEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          service_ButtonPress,
   input  logic [3:0]          officer_ButtonPress,
   output logic [TICKET_W-1:0] Tickernum,
   output logic [1:0]          Desknum,
   output logic [15:0]         ticket_WaitingCustomers,
   output logic [2:0]          ticket_ServiceType
);

   logic                rst;
   state_e              state_q, state_d;
   logic [2:0]          svc_prev_q, svc_pend_q, svc_pend_d, svc_rise_c, svc_clr_c;
   logic [3:0]          off_prev_q, off_pend_q, off_pend_d, off_rise_c, off_clr_c;
   logic [1:0]          sel_q, sel_d;
   logic [TICKET_W-1:0] next_tkt_q, next_tkt_d, tkt_q, tkt_d;
   logic [1:0]          desk_q, desk_d, call_svc_c;
   logic [2:0]          stype_q, stype_d;
   logic [15:0]         wait_q, wait_d;
   logic [2:0]          push_c, pop_c, full_c, empty_c;
   logic [TICKET_W-1:0] head_c [NUM_SVC];
   logic [CNT_W-1:0]    cnt_c  [NUM_SVC];
   logic [CNT_W-1:0]    cnt_n_c [NUM_SVC];
   logic [CNT_W+1:0]    sum_c;

   assign rst = rst_n;

   // Rising-edge requests; a selected request clears but a same-cycle new edge survives
   assign svc_rise_c = service_ButtonPress & ~svc_prev_q;
   assign off_rise_c = officer_ButtonPress & ~off_prev_q;
   assign svc_pend_d = (svc_pend_q & ~svc_clr_c) | svc_rise_c;
   assign off_pend_d = (off_pend_q & ~off_clr_c) | off_rise_c;

   for (genvar g = 0; g < NUM_SVC; g++) begin : g_queue
      ticket_fifo #(.QDEPTH(QDEPTH), .W(TICKET_W)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push_c[g]),
         .data_i  (next_tkt_q),
         .pop_i   (pop_c[g]),
         .data_o  (head_c[g]),
         .count_o (cnt_c[g]),
         .full_o  (full_c[g]),
         .empty_o (empty_c[g])
      );
   end

   // State, request and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         svc_prev_q <= '0;
         off_prev_q <= '0;
         svc_pend_q <= '0;
         off_pend_q <= '0;
         sel_q      <= '0;
         next_tkt_q <= TICKET_FIRST;
         tkt_q      <= '0;
         desk_q     <= '0;
         stype_q    <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         svc_prev_q <= service_ButtonPress;
         off_prev_q <= officer_ButtonPress;
         svc_pend_q <= svc_pend_d;
         off_pend_q <= off_pend_d;
         sel_q      <= sel_d;
         next_tkt_q <= next_tkt_d;
         tkt_q      <= tkt_d;
         desk_q     <= desk_d;
         stype_q    <= stype_d;
         wait_q     <= wait_d;
      end
   end

   // Next-state: arbitrate in IDLE, perform the selected issue or call one cycle later
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      next_tkt_d = next_tkt_q;
      tkt_d      = tkt_q;
      desk_d     = desk_q;
      stype_d    = stype_q;
      svc_clr_c  = '0;
      off_clr_c  = '0;
      push_c     = '0;
      pop_c      = '0;
      call_svc_c = desk_service(sel_q, empty_c);
      case (state_q)
         IDLE: begin
            if (|svc_pend_q) begin
               state_d          = ISSUE;
               sel_d            = lowest_set({1'b0, svc_pend_q});
               svc_clr_c[sel_d] = 1'b1;
            end else if (|off_pend_q) begin
               state_d          = CALL;
               sel_d            = lowest_set(off_pend_q);
               off_clr_c[sel_d] = 1'b1;
            end
         end
         ISSUE: begin
            state_d = IDLE;
            if (!full_c[sel_q]) begin
               push_c[sel_q]  = 1'b1;
               tkt_d          = next_tkt_q;
               stype_d        = '0;
               stype_d[sel_q] = 1'b1;
               next_tkt_d     = (next_tkt_q == TICKET_LAST) ? TICKET_FIRST : next_tkt_q + TICKET_W'(1);
            end
         end
         CALL: begin
            state_d = IDLE;
            if (!empty_c[call_svc_c]) begin
               pop_c[call_svc_c]   = 1'b1;
               tkt_d               = head_c[call_svc_c];
               desk_d              = sel_q;
               stype_d             = '0;
               stype_d[call_svc_c] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Waiting counts track the queues on the same edge as push/pop
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NUM_SVC; i++) begin
         cnt_n_c[i] = cnt_c[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
         sum_c      = sum_c + (CNT_W+2)'(cnt_n_c[i]);
      end
      wait_d = {(sum_c > (CNT_W+2)'(15)) ? 4'hF : sum_c[3:0],
                cnt_n_c[SVC_CUST], cnt_n_c[SVC_LOAN], cnt_n_c[SVC_GEN]};
   end

   assign Tickernum               = tkt_q;
   assign Desknum                 = desk_q;
   assign ticket_WaitingCustomers = wait_q;
   assign ticket_ServiceType      = stype_q;

endmodule

// File: tb/tb_bank_ticket_machine_fsm.sv
// Self-checking bench for bank_ticket_machine_fsm: directed scenarios plus randomized
// button traffic compared against a queue-based behavioural model.
module tb_bank_ticket_machine_fsm;

   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  svc;
   logic [3:0]  off;
   logic [6:0]  tkt;
   logic [1:0]  desk;
   logic [15:0] waitc;
   logic [2:0]  stype;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bank_ticket_machine_fsm #(.QDEPTH(QD)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .service_ButtonPress     (svc),
      .officer_ButtonPress     (off),
      .Tickernum               (tkt),
      .Desknum                 (desk),
      .ticket_WaitingCustomers (waitc),
      .ticket_ServiceType      (stype)
   );

   // Behavioural model: pending request sets, one event in flight, queues of ticket numbers
   int         m_q [3][$];
   logic [6:0] m_next, m_tkt;
   logic [1:0] m_desk;
   logic [2:0] m_stype;
   bit         m_busy, m_is_call;
   int         m_sel;
   bit   [2:0] m_svc_prev, m_svc_pend;
   bit   [3:0] m_off_prev, m_off_pend;

   function automatic logic [15:0] m_wait();
      int t = m_q[0].size() + m_q[1].size() + m_q[2].size();
      if (t > 15) t = 15;
      return {4'(t), 4'(m_q[2].size()), 4'(m_q[1].size()), 4'(m_q[0].size())};
   endfunction

   always @(posedge clk) begin
      int q;
      if (rst_n) begin
         for (int i = 0; i < 3; i++) m_q[i].delete();
         m_next = 7'd1; m_tkt = '0; m_desk = '0; m_stype = '0;
         m_busy = 0; m_is_call = 0; m_sel = 0;
         m_svc_prev = '0; m_svc_pend = '0; m_off_prev = '0; m_off_pend = '0;
      end else begin
         if (m_busy) begin
            m_busy = 0;
            if (!m_is_call) begin
               if (m_q[m_sel].size() < QD) begin
                  m_q[m_sel].push_back(int'(m_next));
                  m_tkt   = m_next;
                  m_stype = 3'(1 << m_sel);
                  m_next  = (m_next == 7'd127) ? 7'd1 : m_next + 7'd1;
               end
            end else begin
               q = -1;
               if (m_sel < 3) q = m_sel;
               else for (int i = 2; i >= 0; i--) if (m_q[i].size() > 0) q = i;
               if (q >= 0 && m_q[q].size() > 0) begin
                  m_tkt   = 7'(m_q[q].pop_front());
                  m_desk  = 2'(m_sel);
                  m_stype = 3'(1 << q);
               end
            end
         end else if (m_svc_pend != 0) begin
            for (int i = 2; i >= 0; i--) if (m_svc_pend[i]) m_sel = i;
            m_svc_pend[m_sel] = 0; m_is_call = 0; m_busy = 1;
         end else if (m_off_pend != 0) begin
            for (int i = 3; i >= 0; i--) if (m_off_pend[i]) m_sel = i;
            m_off_pend[m_sel] = 0; m_is_call = 1; m_busy = 1;
         end
         m_svc_pend = m_svc_pend | (svc & ~m_svc_prev);
         m_off_pend = m_off_pend | (off & ~m_off_prev);
         m_svc_prev = svc;
         m_off_prev = off;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b1; svc = '0; off = '0;
      tick(2);
      rst_n = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; svc = '0; off = '0;
      tick(2);
      checks++;
      if ({tkt, desk, waitc, stype} !== '0) begin
         errors++;
         $display("FAIL reset_held: tkt=%0d desk=%0d wait=%h stype=%b, required all 0", tkt, desk, waitc, stype);
      end
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({tkt, desk, waitc, stype} !== '0) begin
         errors++;
         $display("FAIL reset_released: tkt=%0d desk=%0d wait=%h stype=%b, required all 0", tkt, desk, waitc, stype);
      end
   endtask

   task automatic test_service_sequence();
      do_reset();
      svc = 3'b001; tick(8);
      checks++;
      if (tkt !== 7'd1 || stype !== 3'b001 || waitc !== 16'h1001) begin
         errors++;
         $display("FAIL svc_gen: tkt=%0d stype=%b wait=%h, required 1/001/1001", tkt, stype, waitc);
      end
      svc = 3'b010; tick(4);
      checks++;
      if (tkt !== 7'd2 || stype !== 3'b010 || waitc !== 16'h2011) begin
         errors++;
         $display("FAIL svc_loan: tkt=%0d stype=%b wait=%h, required 2/010/2011", tkt, stype, waitc);
      end
      svc = 3'b100; tick(4);
      svc = 3'b000; tick(4);
      checks++;
      if (tkt !== 7'd3 || stype !== 3'b100 || waitc !== 16'h3111 || desk !== 2'd0) begin
         errors++;
         $display("FAIL svc_cust: tkt=%0d stype=%b wait=%h desk=%0d, required 3/100/3111/0", tkt, stype, waitc, desk);
      end
   endtask

   task automatic test_officer_sequence();
      off = 4'b0001; tick(4);
      checks++;
      if (tkt !== 7'd1 || desk !== 2'd0 || stype !== 3'b001 || waitc !== 16'h2110) begin
         errors++;
         $display("FAIL call_desk0: tkt=%0d desk=%0d stype=%b wait=%h, required 1/0/001/2110", tkt, desk, stype, waitc);
      end
      off = 4'b0010; tick(4);
      checks++;
      if (tkt !== 7'd2 || desk !== 2'd1 || stype !== 3'b010 || waitc !== 16'h1100) begin
         errors++;
         $display("FAIL call_desk1: tkt=%0d desk=%0d stype=%b wait=%h, required 2/1/010/1100", tkt, desk, stype, waitc);
      end
      off = 4'b0100; tick(4);
      off = 4'b0000; tick(2);
      checks++;
      if (tkt !== 7'd3 || desk !== 2'd2 || stype !== 3'b100 || waitc !== 16'h0000) begin
         errors++;
         $display("FAIL call_desk2: tkt=%0d desk=%0d stype=%b wait=%h, required 3/2/100/0000", tkt, desk, stype, waitc);
      end
   endtask

   task automatic test_empty_call();
      off = 4'b1000; tick(4);
      off = 4'b0000; tick(2);
      checks++;
      if (tkt !== 7'd3 || desk !== 2'd2 || stype !== 3'b100 || waitc !== 16'h0000) begin
         errors++;
         $display("FAIL empty_call: tkt=%0d desk=%0d stype=%b wait=%h, required 3/2/100/0000", tkt, desk, stype, waitc);
      end
   endtask

   task automatic test_full_queue();
      do_reset();
      repeat (5) begin
         svc = 3'b001; tick(1);
         svc = 3'b000; tick(3);
      end
      checks++;
      if (tkt !== 7'd4 || waitc !== 16'h4004) begin
         errors++;
         $display("FAIL full_drop: tkt=%0d wait=%h, required 4/4004", tkt, waitc);
      end
      svc = 3'b010; tick(1);
      svc = 3'b000; tick(3);
      checks++;
      if (tkt !== 7'd5 || stype !== 3'b010 || waitc !== 16'h5014) begin
         errors++;
         $display("FAIL full_next_loan: tkt=%0d stype=%b wait=%h, required 5/010/5014", tkt, stype, waitc);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      svc = 3'b011; off = 4'b0001;
      tick(2);
      checks++;
      if (tkt !== 7'd0 || waitc !== 16'h0000) begin
         errors++;
         $display("FAIL latency_early: tkt=%0d wait=%h, required 0/0000", tkt, waitc);
      end
      tick(1);
      checks++;
      if (tkt !== 7'd1 || stype !== 3'b001 || waitc !== 16'h1001) begin
         errors++;
         $display("FAIL simul_gen: tkt=%0d stype=%b wait=%h, required 1/001/1001", tkt, stype, waitc);
      end
      svc = 3'b000; off = 4'b0000;
      tick(2);
      checks++;
      if (tkt !== 7'd2 || stype !== 3'b010 || waitc !== 16'h2011) begin
         errors++;
         $display("FAIL simul_loan: tkt=%0d stype=%b wait=%h, required 2/010/2011", tkt, stype, waitc);
      end
      tick(2);
      checks++;
      if (tkt !== 7'd1 || desk !== 2'd0 || stype !== 3'b001 || waitc !== 16'h1010) begin
         errors++;
         $display("FAIL simul_call: tkt=%0d desk=%0d stype=%b wait=%h, required 1/0/001/1010", tkt, desk, stype, waitc);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 1; i <= 127; i++) begin
         svc = 3'b001; off = 4'b0001; tick(1);
         svc = 3'b000; off = 4'b0000; tick(5);
         checks++;
         if (tkt !== 7'(i) || waitc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_cycle_%0d: tkt=%0d wait=%h, required %0d/0000", i, tkt, waitc, i);
         end
      end
      svc = 3'b001; tick(1);
      svc = 3'b000; tick(3);
      checks++;
      if (tkt !== 7'd1 || stype !== 3'b001 || waitc !== 16'h1001) begin
         errors++;
         $display("FAIL wrap_to_1: tkt=%0d stype=%b wait=%h, required 1/001/1001", tkt, stype, waitc);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         tick(1);
         checks++;
         if (tkt !== m_tkt || desk !== m_desk || stype !== m_stype || waitc !== m_wait()) begin
            errors++;
            $display("FAIL random_c%0d: tkt=%0d desk=%0d stype=%b wait=%h, required %0d/%0d/%b/%h",
                     c, tkt, desk, stype, waitc, m_tkt, m_desk, m_stype, m_wait());
         end
         rst_n = ($urandom_range(0, 199) == 0);
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) svc[b] = ~svc[b];
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) off[b] = ~off[b];
      end
      rst_n = 1'b0; svc = '0; off = '0;
      tick(2);
   endtask

   initial begin
      rst_n = 1'b1; svc = '0; off = '0;
      test_reset();
      test_service_sequence();
      test_officer_sequence();
      test_empty_call();
      test_full_queue();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
